testdrive_axi_master_engine: RTL and testbench
==============================================

# testdrive_axi_master_engine

Single-outstanding AXI4 master that turns one command (direction, address, beat count) into one INCR burst on the AXI bus. It streams write data in from a local valid/ready port and streams read data out to another one. It sits on the initiator side of the system bus, opposite the testdrive AXI slave BFM. It is used by simulation-side DMA and register-test engines to drive bursts into the bus and memory model.

## Interface
Parameters:
- C_THREAD_ID_WIDTH, 1, width of AWID/ARID/BID/RID
- C_ADDR_WIDTH, 32, address width
- C_DATA_WIDTH, 32, data width; power of two, 8..1024
- C_ID, 0, constant ID driven on AWID/ARID

Ports (name, direction, width, meaning):
- CLK, in, 1, clock; all logic on the rising edge
- nRST, in, 1, reset; asynchronous, active-low
- CMD_VALID / CMD_READY, in / out, 1 / 1, command handshake
- CMD_WRITE, in, 1, 1 = write burst, 0 = read burst
- CMD_ADDR, in, C_ADDR_WIDTH, start address; must be aligned to C_DATA_WIDTH/8
- CMD_LEN, in, 8, beats minus one
- WR_DATA / WR_VALID / WR_READY, in / in / out, C_DATA_WIDTH / 1 / 1, write data source
- RD_DATA / RD_LAST / RD_VALID / RD_READY, out / out / out / in, C_DATA_WIDTH / 1 / 1 / 1, read data sink
- DONE, out, 1, one-cycle pulse at command completion
- DONE_RESP, out, 2, completion status: worst AXI response, or b10 on protocol fault
- CMD_ERR, out, 1, one-cycle pulse when a command is rejected
- AW*: AWID, AWADDR, AWLEN[7:0], AWSIZE, AWBURST, AWLOCK[1:0], AWCACHE, AWPROT, AWREGION, AWQOS, AWVALID out; AWREADY in
- W*: WID, WDATA, WSTRB, WLAST, WVALID out; WREADY in
- B*: BID, BRESP, BVALID in; BREADY out
- AR*: same set as AW*, outputs; ARREADY in
- R*: RID, RDATA, RRESP, RLAST, RVALID in; RREADY out

## Operation
- States: IDLE, AADDR, WDATA, WRESP, RDATA, FIN.
- IDLE:
  - CMD_READY=1.
  - On handshake, register the address, length and direction.
  - If (CMD_ADDR[11:0] + (CMD_LEN+1)*bytes) > 4096: no bus activity; pulse CMD_ERR the next cycle and stay in IDLE.
  - Otherwise go to AADDR.
- AADDR:
  - Drive AWVALID or ARVALID from registers; hold until READY.
  - Then go to WDATA (write) or RDATA (read).
- WDATA:
  - WVALID=WR_VALID, WR_READY=WREADY, WDATA=WR_DATA.
  - The beat counter is loaded with CMD_LEN and decrements per W handshake.
  - WLAST=1 when the counter is 0. After the last handshake go to WRESP.
- WRESP: BREADY=1; on BVALID capture BRESP and go to FIN.
- RDATA:
  - RD_VALID=RVALID, RREADY=RD_READY, RD_DATA=RDATA, RD_LAST=(counter==0).
  - Decrement per R handshake.
  - Status accumulates the maximum RRESP seen.
  - If RLAST differs from (counter==0) on any beat, status is forced to b10.
  - After the counter-0 beat go to FIN.
- FIN: DONE=1 and DONE_RESP=status for one cycle, then IDLE.
- Fixed fields:
  - AxSIZE=log2(C_DATA_WIDTH/8), AxBURST=b01 (INCR).
  - AxLOCK, AxCACHE, AxPROT, AxREGION, AxQOS = 0.
  - WSTRB all ones; WID=AWID=ARID=C_ID.
- BID/RID are ignored.

## Timing
- Reset state:
  - State IDLE; all VALID, READY and LAST outputs 0, except CMD_READY=1 once nRST is high.
  - DONE=0, DONE_RESP=0, CMD_ERR=0, address/len registers 0.
- Assertion of nRST mid-burst aborts immediately and asynchronously: AWVALID, ARVALID and WVALID drop. No DONE is issued.
- Minimum write latency: command handshake → AWVALID 1 cycle.
- A single-beat write with always-ready slave and data: CMD cycle 0, AW cycle 1, W cycle 2, B cycle 3 (if BVALID), DONE cycle 4.
- A read with ARREADY and a data beat on consecutive cycles gives DONE one cycle after the last R handshake.
- VALID is never deasserted before its READY once raised in AADDR. WVALID/RREADY track the local ports combinationally (no added latency, no buffering).
- Address and len registers are stable from AADDR through FIN.
- CMD_LEN=0: a single beat with WLAST/RD_LAST=1.
- CMD_LEN=255: 256 beats; the counter must not wrap before the last beat.
- BVALID arriving in the same cycle as the last W handshake is not sampled. WRESP starts the next cycle, so the slave must hold BVALID.

## Structure
- Package testdrive_axi_master_pkg:
  - State enum.
  - Burst/response constants: BURST_INCR, RESP_OKAY, RESP_SLVERR.
  - A function returning log2 bytes for AxSIZE.
- No sub-module needed. A single FSM plus an 8-bit beat counter and a 2-bit status register is roughly 200 lines.

## Test plan
- Write: CMD_ADDR=0x100, LEN=3, data 0..3, slave always ready → AWADDR=0x100, AWLEN=3, 4 W beats with WLAST on beat 3, DONE with DONE_RESP=b00.
- Read: ADDR=0x2000, LEN=7, slave returns RRESP=b00 except beat 5 b10 → 8 RD beats, RD_LAST on beat 7, DONE_RESP=b10.
- Backpressure: random AWREADY/WREADY/WR_VALID/RD_READY stalls over a LEN=15 write and read → AXI VALID stable until READY, data order preserved, exactly one DONE each.
- 4 KB crossing: ADDR=0xFF0, LEN=7, 32-bit data → CMD_ERR pulse, no AWVALID/ARVALID, CMD_READY back to 1 next cycle.
- RLAST fault: slave asserts RLAST on beat 2 of a LEN=3 read → DONE_RESP=b10 after beat 3.
- Reset mid-write: nRST low during beat 2 of a LEN=7 write → all VALIDs 0 immediately, no DONE; after release, a new LEN=0 write completes normally.

Source files
------------

// File: rtl/testdrive_axi_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// testdrive_axi_master_pkg: shared types and constants for the AXI master engine
// Rev 1.0
// ----------------------------------------------------------------------------
package testdrive_axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AADDR = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [2:0] axsize(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/testdrive_axi_master_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// testdrive_axi_master_engine: single-outstanding AXI4 master, one INCR burst per command
// Rev 1.0
// ----------------------------------------------------------------------------
module testdrive_axi_master_engine
  import testdrive_axi_master_pkg::*;
#(
  parameter int C_THREAD_ID_WIDTH = 1,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_ID              = 0
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic                           CMD_WRITE,
  input  logic [C_ADDR_WIDTH-1:0]        CMD_ADDR,
  input  logic [7:0]                     CMD_LEN,
  input  logic [C_DATA_WIDTH-1:0]        WR_DATA,
  input  logic                           WR_VALID,
  output logic                           WR_READY,
  output logic [C_DATA_WIDTH-1:0]        RD_DATA,
  output logic                           RD_LAST,
  output logic                           RD_VALID,
  input  logic                           RD_READY,
  output logic                           DONE,
  output logic [1:0]                     DONE_RESP,
  output logic                           CMD_ERR,
  output logic [C_THREAD_ID_WIDTH-1:0]   AWID,
  output logic [C_ADDR_WIDTH-1:0]        AWADDR,
  output logic [7:0]                     AWLEN,
  output logic [2:0]                     AWSIZE,
  output logic [1:0]                     AWBURST,
  output logic [1:0]                     AWLOCK,
  output logic [3:0]                     AWCACHE,
  output logic [2:0]                     AWPROT,
  output logic [3:0]                     AWREGION,
  output logic [3:0]                     AWQOS,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [C_THREAD_ID_WIDTH-1:0]   WID,
  output logic [C_DATA_WIDTH-1:0]        WDATA,
  output logic [C_DATA_WIDTH/8-1:0]      WSTRB,
  output logic                           WLAST,
  output logic                           WVALID,
  input  logic                           WREADY,
  input  logic [C_THREAD_ID_WIDTH-1:0]   BID,
  input  logic [1:0]                     BRESP,
  input  logic                           BVALID,
  output logic                           BREADY,
  output logic [C_THREAD_ID_WIDTH-1:0]   ARID,
  output logic [C_ADDR_WIDTH-1:0]        ARADDR,
  output logic [7:0]                     ARLEN,
  output logic [2:0]                     ARSIZE,
  output logic [1:0]                     ARBURST,
  output logic [1:0]                     ARLOCK,
  output logic [3:0]                     ARCACHE,
  output logic [2:0]                     ARPROT,
  output logic [3:0]                     ARREGION,
  output logic [3:0]                     ARQOS,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  input  logic [C_THREAD_ID_WIDTH-1:0]   RID,
  input  logic [C_DATA_WIDTH-1:0]        RDATA,
  input  logic [1:0]                     RRESP,
  input  logic                           RLAST,
  input  logic                           RVALID,
  output logic                           RREADY
);

  localparam int BYTES = C_DATA_WIDTH / 8;

  state_t                    state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      write_q, write_d;
  logic [1:0]                status_q, status_d;
  logic                      fault_q, fault_d;
  logic                      err_q, err_d;

  logic [16:0]               burst_end;
  logic                      crosses_4k;
  logic                      last_beat;
  logic                      unused_ok;

  // Byte offset within the 4 KB page plus burst size; anything past 4096 spills over.
  assign burst_end  = 17'(CMD_ADDR[11:0]) + (17'(CMD_LEN) + 17'd1) * 17'(BYTES);
  assign crosses_4k = burst_end > 17'd4096;
  assign last_beat  = cnt_q == 8'd0;
  assign unused_ok  = ^{BID, RID};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      status_q <= RESP_OKAY;
      fault_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      status_q <= status_d;
      fault_q  <= fault_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    status_d = status_q;
    fault_d  = fault_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_d   = CMD_ADDR;
          len_d    = CMD_LEN;
          write_d  = CMD_WRITE;
          cnt_d    = CMD_LEN;
          status_d = RESP_OKAY;
          fault_d  = 1'b0;
          if (crosses_4k) err_d = 1'b1;
          else            state_d = ST_AADDR;
        end
      end
      ST_AADDR: begin
        if (write_q ? AWREADY : ARREADY)
          state_d = write_q ? ST_WDATA : ST_RDATA;
      end
      ST_WDATA: begin
        if (WR_VALID && WREADY) begin
          if (last_beat) state_d = ST_WRESP;
          else           cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_WRESP: begin
        if (BVALID) begin
          status_d = BRESP;
          state_d  = ST_FIN;
        end
      end
      ST_RDATA: begin
        if (RVALID && RD_READY) begin
          if (RRESP > status_q) status_d = RRESP;
          // A misplaced RLAST is sticky: the completion reports SLVERR regardless.
          if (RLAST != last_beat) fault_d = 1'b1;
          if (last_beat) state_d = ST_FIN;
          else           cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign CMD_READY = (state_q == ST_IDLE) && nRST;
  assign CMD_ERR   = err_q;
  assign DONE      = state_q == ST_FIN;
  assign DONE_RESP = (state_q == ST_FIN) ? (fault_q ? RESP_SLVERR : status_q) : RESP_OKAY;

  assign AWID     = C_THREAD_ID_WIDTH'(C_ID);
  assign AWADDR   = addr_q;
  assign AWLEN    = len_q;
  assign AWSIZE   = axsize(C_DATA_WIDTH);
  assign AWBURST  = BURST_INCR;
  assign AWLOCK   = 2'b00;
  assign AWCACHE  = 4'h0;
  assign AWPROT   = 3'b000;
  assign AWREGION = 4'h0;
  assign AWQOS    = 4'h0;
  assign AWVALID  = (state_q == ST_AADDR) && write_q;

  assign ARID     = C_THREAD_ID_WIDTH'(C_ID);
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = axsize(C_DATA_WIDTH);
  assign ARBURST  = BURST_INCR;
  assign ARLOCK   = 2'b00;
  assign ARCACHE  = 4'h0;
  assign ARPROT   = 3'b000;
  assign ARREGION = 4'h0;
  assign ARQOS    = 4'h0;
  assign ARVALID  = (state_q == ST_AADDR) && !write_q;

  assign WID      = C_THREAD_ID_WIDTH'(C_ID);
  assign WDATA    = WR_DATA;
  assign WSTRB    = '1;
  assign WVALID   = (state_q == ST_WDATA) && WR_VALID;
  assign WR_READY = (state_q == ST_WDATA) && WREADY;
  assign WLAST    = (state_q == ST_WDATA) && last_beat;
  assign BREADY   = state_q == ST_WRESP;

  assign RD_DATA  = RDATA;
  assign RD_VALID = (state_q == ST_RDATA) && RVALID;
  assign RD_LAST  = (state_q == ST_RDATA) && last_beat;
  assign RREADY   = (state_q == ST_RDATA) && RD_READY;

endmodule
`default_nettype wire

// File: tb/tb_testdrive_axi_master_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_testdrive_axi_master_engine: directed bench for the AXI master engine
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_testdrive_axi_master_engine;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [7:0]  CMD_LEN;
  logic [31:0] WR_DATA;
  logic        WR_VALID, WR_READY;
  logic [31:0] RD_DATA;
  logic        RD_LAST, RD_VALID, RD_READY;
  logic        DONE;
  logic [1:0]  DONE_RESP;
  logic        CMD_ERR;
  logic [0:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, BRESP, RRESP;
  logic [3:0]  AWCACHE, ARCACHE, AWREGION, ARREGION, AWQOS, ARQOS, WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  testdrive_axi_master_engine dut (
    .CLK(CLK), .nRST(nRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_LAST(RD_LAST), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .DONE(DONE), .DONE_RESP(DONE_RESP), .CMD_ERR(CMD_ERR),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWREGION(AWREGION),
    .AWQOS(AWQOS), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARREGION(ARREGION),
    .ARQOS(ARQOS), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit coin(input bit stall);
    return stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_LEN = len;
    #1 check("cmd_ready", CMD_READY, 1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] bresp, input bit stall);
    int beats, dones, done_cyc;
    bit aw_acc, aw_pend, w_done;
    beats = 0; dones = 0; done_cyc = -1; aw_acc = 0; aw_pend = 0; w_done = 0;
    send_cmd(1'b1, addr, len);
    for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      AWREADY  = coin(stall);
      WREADY   = coin(stall);
      WR_VALID = coin(stall) && !w_done;
      WR_DATA  = 32'hD000_0000 | 32'(beats);
      BVALID   = w_done;
      BRESP    = bresp;
      #1;
      if (cyc == 0 && !stall) check("aw_latency", AWVALID, 1);
      if (aw_pend) check("awvalid_hold", AWVALID, 1);
      check("arvalid_in_write", ARVALID, 0);
      if (AWVALID) begin
        check("awaddr", AWADDR, addr);
        check("awlen", AWLEN, len);
        check("aw_fixed", {AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWREGION, AWQOS},
              {1'b0, 3'd2, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0, 4'h0});
      end
      aw_pend = AWVALID && !AWREADY;
      if (aw_acc && !w_done) begin
        check("wvalid_track", WVALID, WR_VALID);
        check("wr_ready_track", WR_READY, WREADY);
      end
      if (AWVALID && AWREADY) aw_acc = 1;
      if (WVALID && WREADY) begin
        check("wdata", WDATA, 32'hD000_0000 | 32'(beats));
        check("wlast", WLAST, beats == int'(len));
        check("wstrb_wid", {WSTRB, WID}, {4'hF, 1'b0});
        beats++;
        if (beats == int'(len) + 1) w_done = 1;
      end
      if (DONE) begin
        dones++;
        done_cyc = cyc;
        check("write_done_resp", DONE_RESP, bresp);
      end
      @(negedge CLK);
    end
    BVALID = 1'b0; WR_VALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    #1;
    check("done_pulse_end", DONE, 0);
    check("cmd_ready_after", CMD_READY, 1);
    check("w_beats", beats, int'(len) + 1);
    check("write_done_count", dones, 1);
    if (!stall) check("write_done_cycle", done_cyc, int'(len) + 3);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input int err_beat, input logic [1:0] err_resp,
                         input int rlast_beat, input logic [1:0] exp_resp, input bit stall);
    int beats, dones, done_cyc;
    bit ar_acc, ar_pend, r_done;
    beats = 0; dones = 0; done_cyc = -1; ar_acc = 0; ar_pend = 0; r_done = 0;
    send_cmd(1'b0, addr, len);
    for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      ARREADY  = coin(stall);
      RVALID   = ar_acc && !r_done && coin(stall);
      RDATA    = 32'hA500_0000 | 32'(beats);
      RRESP    = (beats == err_beat) ? err_resp : 2'b00;
      RLAST    = beats == rlast_beat;
      RD_READY = coin(stall);
      #1;
      if (cyc == 0 && !stall) check("ar_latency", ARVALID, 1);
      if (ar_pend) check("arvalid_hold", ARVALID, 1);
      check("awvalid_in_read", AWVALID, 0);
      if (ARVALID) begin
        check("araddr", ARADDR, addr);
        check("arlen", ARLEN, len);
        check("ar_fixed", {ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARREGION, ARQOS},
              {1'b0, 3'd2, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0, 4'h0});
      end
      ar_pend = ARVALID && !ARREADY;
      if (ar_acc && !r_done) begin
        check("rd_valid_track", RD_VALID, RVALID);
        check("rready_track", RREADY, RD_READY);
      end
      if (ARVALID && ARREADY) ar_acc = 1;
      if (RVALID && RREADY) begin
        check("rd_data", RD_DATA, 32'hA500_0000 | 32'(beats));
        check("rd_last", RD_LAST, beats == int'(len));
        beats++;
        if (beats == int'(len) + 1) r_done = 1;
      end
      if (DONE) begin
        dones++;
        done_cyc = cyc;
        check("read_done_resp", DONE_RESP, exp_resp);
      end
      @(negedge CLK);
    end
    RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b0; RD_READY = 1'b0;
    #1;
    check("done_pulse_end", DONE, 0);
    check("cmd_ready_after", CMD_READY, 1);
    check("r_beats", beats, int'(len) + 1);
    check("read_done_count", dones, 1);
    if (!stall) check("read_done_cycle", done_cyc, int'(len) + 2);
  endtask

  initial begin
    nRST = 1'b0;
    CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = '0; CMD_LEN = '0;
    WR_DATA = '0; WR_VALID = 0; RD_READY = 0;
    AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
    ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;

    // Reset state
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("reset_cmd_ready", CMD_READY, 1);
    check("reset_flags", {AWVALID, ARVALID, WVALID, RD_VALID, RREADY, BREADY, WR_READY,
                          WLAST, RD_LAST, DONE, CMD_ERR}, 11'b0);
    check("reset_done_resp", DONE_RESP, 2'b00);
    check("reset_addr_len", {AWADDR, AWLEN}, 40'h0);

    // Basic write and read with a SLVERR beat
    do_write(32'h100, 8'd3, 2'b00, 1'b0);
    do_read(32'h2000, 8'd7, 5, 2'b10, 7, 2'b10, 1'b0);

    // Backpressure on every handshake
    do_write(32'h500, 8'd15, 2'b00, 1'b1);
    do_read(32'h600, 8'd15, -1, 2'b00, 15, 2'b00, 1'b1);

    // 4 KB crossing is rejected; exactly reaching the boundary is accepted
    send_cmd(1'b1, 32'hFF0, 8'd7);
    #1;
    check("cmd_err_pulse", CMD_ERR, 1);
    check("err_no_valid", {AWVALID, ARVALID}, 2'b00);
    check("err_cmd_ready", CMD_READY, 1);
    @(negedge CLK);
    #1;
    check("cmd_err_clear", CMD_ERR, 0);
    check("err_no_valid2", {AWVALID, ARVALID}, 2'b00);
    do_read(32'hFE0, 8'd7, -1, 2'b00, 7, 2'b00, 1'b0);

    // Early RLAST forces SLVERR
    do_read(32'h700, 8'd3, -1, 2'b00, 2, 2'b10, 1'b0);

    // Reset in the middle of a write burst
    send_cmd(1'b1, 32'h300, 8'd7);
    AWREADY = 1; WREADY = 1; WR_VALID = 1; WR_DATA = 32'h1234;
    repeat (3) @(negedge CLK);
    #1 check("pre_reset_wvalid", WVALID, 1);
    nRST = 1'b0;
    #1 check("reset_abort", {AWVALID, ARVALID, WVALID, DONE}, 4'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1 check("reset_no_done", {DONE, WVALID}, 2'b00);
    end
    WR_VALID = 0; AWREADY = 0; WREADY = 0;
    @(negedge CLK);
    nRST = 1'b1;
    #1 check("post_reset_idle", {CMD_READY, WLAST, DONE}, 3'b100);
    do_write(32'h400, 8'd0, 2'b10, 1'b0);

    // Longest burst: 256 beats without counter wrap
    do_write(32'h0, 8'd255, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
